piso6_tx: RTL and testbench
===========================

PISO6_TX -- requirements
Module: piso6_tx

Interface
REQ-001 Parameter: MSB_FIRST, default 1; 1 = shift bit 5 first, 0 = shift bit 0 first.
REQ-002 Port: clk  input  1  rising-edge clock; single clock domain.
REQ-003 Port: rst  input  1  synchronous, active-high reset; sampled on the clk rising edge.
REQ-004 Port: I  input  6  parallel word to be serialized.
REQ-005 Port: ld_valid  input  1  I holds a word to be sent.
REQ-006 Port: ld_ready  output  1  block can accept a word this cycle.
REQ-007 Port: sout  output  1  serial data bit.
REQ-008 Port: sframe  output  1  high in every cycle in which sout carries a valid frame bit.
REQ-009 Port: done  output  1  one-cycle pulse after the last frame bit.

Function
REQ-010 States SHALL be IDLE, SHIFT and DONE.
REQ-011 IDLE outputs SHALL be: ld_ready=1, sframe=0, sout=0, done=0.
REQ-012 Accept: on an edge where ld_valid=1 and ld_ready=1, the block SHALL capture I into a 6-bit shift register, clear the bit counter and go to SHIFT.
REQ-013 SHIFT outputs SHALL be: ld_ready=0, sframe=1, sout=current bit.
- Bit order per MSB_FIRST; one bit per cycle.
- The bit counter SHALL count 0..5 and SHALL NOT wrap within a frame.
REQ-014 Latency: for an accept at edge N, data bits SHALL appear in cycles N+1..N+6.
- done=1 SHALL occur in cycle N+7 without parity, N+8 with parity.
REQ-015 DONE SHALL last exactly one cycle with done=1, ld_ready=0, sframe=0, sout=0, then return to IDLE.
REQ-016 Back-to-back: the next accept SHALL be possible at the edge ending the first IDLE cycle after DONE; gap = 1 idle cycle minimum.
REQ-017 ld_valid and I SHALL be ignored outside IDLE; changes to I during SHIFT SHALL NOT alter the frame in flight.
REQ-018 ld_valid held high continuously SHALL produce consecutive frames separated by DONE plus one IDLE cycle.

Reset
REQ-019 rst=1 at an edge SHALL force IDLE, shift register=0, counter=0, and all outputs to their REQ-011 values, from the following cycle.
REQ-020 rst SHALL override everything, including a simultaneous accept.
REQ-021 Reset mid-frame SHALL abort the frame and SHALL produce no done pulse.

Configuration
REQ-022 Macro PISO6_TX_PARITY_EN selects parity.
- Defined: one extra SHIFT cycle after bit 5, with sframe=1 and sout = even parity (XOR of the 6 captured bits).
- Undefined: no parity cycle; frame = 6 bits.
- All other timing is identical in both builds.

Structure
REQ-023 Shared package piso6_pkg SHALL hold:
- the state enum (IDLE, SHIFT, DONE);
- constant PISO6_W=6;
- the counter width constant;
- a parity-length constant derived from PISO6_TX_PARITY_EN.
REQ-024 One sub-module, piso6_bitcnt, SHALL implement the frame bit counter: clear, enable, last-bit flag. All other logic stays in piso6_tx.

Verification
REQ-025 Reset: assert rst 2 cycles -> ld_ready=1, sframe=0, sout=0, done=0 in the first cycle after release.
REQ-026 Single frame: I=6'b101100, ld_valid one cycle, MSB_FIRST=1 -> sout = 1,0,1,1,0,0 with sframe=1 for 6 cycles; done at N+7 without parity, N+8 with parity bit 1.
REQ-027 LSB order: MSB_FIRST=0, I=6'b000011 -> sout = 1,1,0,0,0,0; parity build adds 0.
REQ-028 Busy ignore: accept 6'b111111, then drive I=6'b000000 with ld_valid=1 during SHIFT -> six 1s sent; the second word is accepted only after DONE+IDLE.
REQ-029 Reset mid-frame: rst at the 3rd SHIFT cycle -> sframe=0 next cycle, no done pulse, ld_ready=1.
REQ-030 Streaming: ld_valid held high with 3 different words -> 3 complete frames, each followed by one done pulse and one IDLE cycle.

Source files
------------

// File: rtl/piso6_pkg.sv
// Shared definitions for the 6-bit PISO transmitter.
// Optional feature macro: PISO6_TX_PARITY_EN (adds an even-parity bit after bit 5).
package piso6_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } piso6_state_t;

  localparam int unsigned PISO6_W     = 6;
  localparam int unsigned PISO6_CNT_W = 3;

`ifdef PISO6_TX_PARITY_EN
  localparam int unsigned PISO6_PAR_LEN = 1;
`else
  localparam int unsigned PISO6_PAR_LEN = 0;
`endif

  localparam int unsigned PISO6_FRAME_LEN = PISO6_W + PISO6_PAR_LEN;

endpackage

// File: rtl/piso6_bitcnt.sv
// Frame bit counter: counts data bits 0..5, saturates on the last bit.
module piso6_bitcnt
  import piso6_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam logic [PISO6_CNT_W-1:0] LAST_IDX = PISO6_CNT_W'(PISO6_W - 1);

  logic [PISO6_CNT_W-1:0] cnt;

  // Clear on reset or new frame; advance while enabled, never past the last bit.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && (cnt != LAST_IDX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign last = (cnt == LAST_IDX);

endmodule

// File: rtl/piso6_tx.sv
// 6-bit parallel-in serial-out transmitter with frame/done handshake.
// Optional feature macro: PISO6_TX_PARITY_EN (one extra even-parity bit per frame).
module piso6_tx
  import piso6_pkg::*;
#(
  parameter int unsigned MSB_FIRST = 1
)
(
  input  logic               clk,
  input  logic               rst,
  input  logic [PISO6_W-1:0] I,
  input  logic               ld_valid,
  output logic               ld_ready,
  output logic               sout,
  output logic               sframe,
  output logic               done
);

  localparam bit MSB = (MSB_FIRST != 0);

  piso6_state_t       state;
  logic [PISO6_W-1:0] sreg;
  logic               cnt_clr;
  logic               cnt_en;
  logic               cnt_last;

`ifdef PISO6_TX_PARITY_EN
  logic par_bit;
  logic par_phase;
`endif

  assign cnt_clr = (state == IDLE) && ld_valid;
  assign cnt_en  = (state == SHIFT) && !cnt_last;

  piso6_bitcnt u_bitcnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .last (cnt_last)
  );

  // Frame FSM with registered outputs; the shift register rotates so the
  // next bit to send always sits next to the current one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sreg     <= '0;
      ld_ready <= 1'b1;
      sframe   <= 1'b0;
      sout     <= 1'b0;
      done     <= 1'b0;
`ifdef PISO6_TX_PARITY_EN
      par_bit   <= 1'b0;
      par_phase <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (ld_valid) begin
            state    <= SHIFT;
            sreg     <= I;
            ld_ready <= 1'b0;
            sframe   <= 1'b1;
            sout     <= MSB ? I[PISO6_W-1] : I[0];
`ifdef PISO6_TX_PARITY_EN
            par_bit   <= ^I;
            par_phase <= 1'b0;
`endif
          end
        end
        SHIFT: begin
          if (!cnt_last) begin
            sreg <= MSB ? {sreg[PISO6_W-2:0], sreg[PISO6_W-1]}
                        : {sreg[0], sreg[PISO6_W-1:1]};
            sout <= MSB ? sreg[PISO6_W-2] : sreg[1];
          end else begin
`ifdef PISO6_TX_PARITY_EN
            if (!par_phase) begin
              par_phase <= 1'b1;
              sout      <= par_bit;
            end else begin
              state  <= DONE;
              sframe <= 1'b0;
              sout   <= 1'b0;
              done   <= 1'b1;
            end
`else
            state  <= DONE;
            sframe <= 1'b0;
            sout   <= 1'b0;
            done   <= 1'b1;
`endif
          end
        end
        DONE: begin
          state    <= IDLE;
          done     <= 1'b0;
          ld_ready <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          ld_ready <= 1'b1;
          sframe   <= 1'b0;
          sout     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso6_tx.sv
// Self-checking bench for piso6_tx: two instances (MSB-first and LSB-first)
// share the same stimulus and are compared every cycle against a frame model.
module tb_piso6_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] I = '0;
  logic       ld_valid = 1'b0;

  logic rdy_m, sout_m, sf_m, done_m;
  logic rdy_l, sout_l, sf_l, done_l;

  always #5 clk = ~clk;

  piso6_tx #(.MSB_FIRST(1)) dut_m (
    .clk(clk), .rst(rst), .I(I), .ld_valid(ld_valid),
    .ld_ready(rdy_m), .sout(sout_m), .sframe(sf_m), .done(done_m)
  );

  piso6_tx #(.MSB_FIRST(0)) dut_l (
    .clk(clk), .rst(rst), .I(I), .ld_valid(ld_valid),
    .ld_ready(rdy_l), .sout(sout_l), .sframe(sf_l), .done(done_l)
  );

`ifdef PISO6_TX_PARITY_EN
  localparam int FL = 7;
`else
  localparam int FL = 6;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame as a list of bits in transmit order; entry 6 is the parity bit.
  function automatic logic [6:0] build(input logic [5:0] w, input bit msb);
    logic [6:0] f;
    f = '0;
    for (int k = 0; k < 6; k++) f[k] = msb ? w[5-k] : w[k];
    f[6] = ^w;
    return f;
  endfunction

  // Expected {ld_ready, sframe, sout, done} for a position in the frame.
  function automatic logic [3:0] mexp(input int p, input logic [6:0] f);
    if (p < 0) return 4'b1000;
    if (p < FL) return {2'b01, f[p], 1'b0};
    return 4'b0001;
  endfunction

  // Model: pos = -1 idle, 0..FL-1 frame bit, FL the done cycle.
  int         pos = -1;
  logic [6:0] fr_m = '0;
  logic [6:0] fr_l = '0;

  always @(posedge clk) begin
    if (rst) begin
      pos <= -1;
    end else if (pos < 0) begin
      if (ld_valid) begin
        pos  <= 0;
        fr_m <= build(I, 1'b1);
        fr_l <= build(I, 1'b0);
      end
    end else if (pos == FL) begin
      pos <= -1;
    end else begin
      pos <= pos + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("msb_outs", int'({rdy_m, sf_m, sout_m, done_m}), int'(mexp(pos, fr_m)));
      check("lsb_outs", int'({rdy_l, sf_l, sout_l, done_l}), int'(mexp(pos, fr_l)));
    end
  end

  // One frame with literal expectations for both bit orders and the done latency.
  task automatic frame_lit(input logic [5:0] w, input logic [6:0] em, input logic [6:0] el,
                           input string nm);
    logic [6:0] gm, gl;
    int nb, lat;
    gm = '0; gl = '0; nb = 0; lat = 0;
    @(negedge clk); I = w; ld_valid = 1'b1;
    @(negedge clk); ld_valid = 1'b0; I = ~w; lat = 1;
    while (!done_m && lat < 20) begin
      if (sf_m && nb < 7) begin
        gm[nb] = sout_m;
        gl[nb] = sout_l;
        nb++;
      end
      @(negedge clk); lat++;
    end
    check({nm, "_nbits"}, nb, FL);
    check({nm, "_done_lat"}, lat, FL + 1);
    check({nm, "_bits_msb"}, int'(gm), int'((FL == 7) ? em : (em & 7'h3f)));
    check({nm, "_bits_lsb"}, int'(gl), int'((FL == 7) ? el : (el & 7'h3f)));
  endtask

  initial begin
    int k, ones, rise_at, dn, sfc, rdyc;
    logic prev_sf;
    logic [5:0] words [3];

    // Reset held for two edges.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("reset_msb", int'({rdy_m, sf_m, sout_m, done_m}), 4'b1000);
    check("reset_lsb", int'({rdy_l, sf_l, sout_l, done_l}), 4'b1000);

    // Single frames: 101100 and 000011.
    frame_lit(6'b101100, 7'b1001101, 7'b1101100, "f101100");
    frame_lit(6'b000011, 7'b0110000, 7'b0000011, "f000011");

    // Busy ignore: second word presented during SHIFT waits for DONE + IDLE.
    @(negedge clk); I = 6'b111111; ld_valid = 1'b1;
    @(negedge clk); I = 6'b000000;
    k = 1; ones = 0; rise_at = 0; prev_sf = 1'b0;
    while (rise_at == 0 && k < 30) begin
      if (sf_m && !prev_sf && k > 1) rise_at = k;
      if (sf_m && rise_at == 0 && sout_m) ones++;
      prev_sf = sf_m;
      @(negedge clk); k++;
    end
    ld_valid = 1'b0;
    check("busy_ones", ones, (FL == 7) ? 6 : 6);
    check("busy_restart", rise_at, FL + 3);
    k = 0;
    while (!rdy_m && k < 20) begin @(negedge clk); k++; end
    check("busy_drain", int'(rdy_m), 1);

    // Reset during the third SHIFT cycle.
    @(negedge clk); I = 6'b110101; ld_valid = 1'b1;
    @(negedge clk); ld_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("midrst_state", int'({rdy_m, sf_m, done_m}), 3'b100);
    dn = 0;
    for (int c = 0; c < 12; c++) begin
      if (done_m || done_l) dn++;
      @(negedge clk);
    end
    check("midrst_nodone", dn, 0);

    // Streaming: ld_valid held high across three words.
    words[0] = 6'b100110; words[1] = 6'b011001; words[2] = 6'b111000;
    dn = 0; sfc = 0; rdyc = 0; k = 0;
    I = words[0]; ld_valid = 1'b1;
    @(negedge clk);
    while (dn < 3 && k < 60) begin
      if (sf_m) sfc++;
      if (rdy_m && dn > 0) rdyc++;
      if (done_m) begin
        dn++;
        if (dn < 3) I = words[dn];
      end
      @(negedge clk); k++;
    end
    ld_valid = 1'b0;
    check("stream_dones", dn, 3);
    check("stream_bits", sfc, 3 * FL);
    check("stream_gaps", rdyc, 2);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      I = 6'($urandom);
      ld_valid = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 63) == 0);
    end
    @(negedge clk); rst = 1'b0; ld_valid = 1'b0;
    repeat (12) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
